// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock parametrised FIFO, standard or fall-through read, with count/threshold flags and pulse status
module sync_fifo_param #(
  parameter int DATA_W    = 14,
  parameter int ADDR_W    = 10,
  parameter int AF_THRESH = 1020,
  parameter int AE_THRESH = 4,
  parameter int FWFT      = 0
) (
  input  logic              sclk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              valid,
  output logic              wr_ack,
  output logic              overflow,
  output logic              underflow,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   data_count
);
  localparam int DEPTH = 2 ** ADDR_W;
  if (DATA_W < 1 || DATA_W > 64 || ADDR_W < 2 || ADDR_W > 12 || AF_THRESH < 1 || AF_THRESH > DEPTH ||
      AE_THRESH < 0 || AE_THRESH > DEPTH - 1 || FWFT < 0 || FWFT > 1) begin : g_cfg_err
    $error("sync_fifo_param: parameter out of range");
  end
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] dout_q, dout_d, head;
  logic              valid_q, valid_d, wr_acc, rd_acc, wr_ack_q, overflow_q, underflow_q;
  always_comb begin
    full         = count_q == (ADDR_W+1)'(DEPTH);
    empty        = count_q == '0;
    almost_full  = count_q >= (ADDR_W+1)'(AF_THRESH);
    almost_empty = count_q <= (ADDR_W+1)'(AE_THRESH);
    wr_acc       = wr_en & ~full;
    rd_acc       = rd_en & ~empty;
    head         = mem_q[rd_ptr_q];
    wr_ptr_d     = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d     = rd_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d      = (wr_acc && !rd_acc) ? count_q + 1'b1 :
                   (rd_acc && !wr_acc) ? count_q - 1'b1 : count_q;
    dout_d       = rd_acc ? head : dout_q;
    valid_d      = rd_acc;
    dout         = (FWFT != 0) ? head : dout_q;
    valid        = (FWFT != 0) ? ~empty : valid_q;
    wr_ack       = wr_ack_q;
    overflow     = overflow_q;
    underflow    = underflow_q;
    data_count   = count_q;
  end
  always_ff @(posedge sclk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= din;
  end
  always_ff @(posedge sclk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      dout_q      <= '0;
      valid_q     <= 1'b0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      dout_q      <= dout_d;
      valid_q     <= valid_d;
      wr_ack_q    <= wr_acc;
      overflow_q  <= wr_en & full;
      underflow_q <= rd_en & empty;
    end
  end
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed self-checking bench for standard and fall-through FIFO configurations
module tb_sync_fifo_param;
  logic        sclk = 1'b0, rst = 1'b1, wr_en = 1'b0, rd_en = 1'b0;
  logic [13:0] din = '0;
  logic [13:0] dout0, dout1;
  logic        valid0, wr_ack0, ovf0, unf0, full0, empty0, af0, ae0;
  logic        valid1, wr_ack1, ovf1, unf1, full1, empty1, af1, ae1;
  logic [4:0]  cnt0, cnt1;
  int          checks = 0, errors = 0;
  logic [13:0] model [$];
  logic [13:0] exp_d;
  always #5 sclk = ~sclk;
  sync_fifo_param #(.DATA_W(14), .ADDR_W(4), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0)) u0 (
    .sclk(sclk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en), .dout(dout0), .valid(valid0),
    .wr_ack(wr_ack0), .overflow(ovf0), .underflow(unf0), .full(full0), .empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .data_count(cnt0));
  sync_fifo_param #(.DATA_W(14), .ADDR_W(4), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1)) u1 (
    .sclk(sclk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en), .dout(dout1), .valid(valid1),
    .wr_ack(wr_ack1), .overflow(ovf1), .underflow(unf1), .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .data_count(cnt1));
  task automatic tick();
    @(posedge sclk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic push(input logic [13:0] d);
    wr_en = 1'b1;
    din = d;
    tick();
    wr_en = 1'b0;
    model.push_back(d);
    chk("push_ack", wr_ack0, 1);
  endtask
  task automatic pop();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    exp_d = model.pop_front();
    chk("pop_valid", valid0, 1);
    chk("pop_dout", dout0, exp_d);
  endtask
  initial begin
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    tick();
    chk("rst_empty", empty0, 1);
    chk("rst_ae", ae0, 1);
    chk("rst_full", full0, 0);
    chk("rst_af", af0, 0);
    chk("rst_count", cnt0, 0);
    chk("rst_valid", valid0, 0);
    chk("rst_dout", dout0, 0);
    chk("rst_pulses", {wr_ack0, ovf0, unf0}, 0);
    for (int i = 0; i < 16; i++) begin
      push(14'(1024 + i));
      chk("fill_count", cnt0, i + 1);
      chk("fill_ae", ae0, (i + 1) <= 2);
      chk("fill_af", af0, (i + 1) >= 14);
      chk("fill_full", full0, i == 15);
    end
    wr_en = 1'b1;
    din = 14'd999;
    tick();
    wr_en = 1'b0;
    chk("ovf_pulse", ovf0, 1);
    chk("ovf_ack", wr_ack0, 0);
    chk("ovf_count", cnt0, 16);
    tick();
    chk("ovf_clear", ovf0, 0);
    for (int i = 0; i < 16; i++) begin
      pop();
      chk("drain_count", cnt0, 15 - i);
    end
    chk("drain_empty", empty0, 1);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("unf_pulse", unf0, 1);
    chk("unf_valid", valid0, 0);
    chk("unf_hold_dout", dout0, 1039);
    tick();
    chk("unf_clear", unf0, 0);
    for (int i = 0; i < 8; i++) push(14'(2000 + i));
    chk("mid_count", cnt0, 8);
    for (int k = 0; k < 5; k++) begin
      wr_en = 1'b1;
      rd_en = 1'b1;
      din = 14'(3000 + k);
      tick();
      model.push_back(din);
      exp_d = model.pop_front();
      chk("both_count", cnt0, 8);
      chk("both_ack", wr_ack0, 1);
      chk("both_valid", valid0, 1);
      chk("both_dout", dout0, exp_d);
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    for (int j = 0; j < 8; j++) push(14'(3010 + j));
    chk("refull", full0, 1);
    wr_en = 1'b1;
    rd_en = 1'b1;
    din = 14'h3ff;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
    exp_d = model.pop_front();
    chk("full_both_count", cnt0, 15);
    chk("full_both_ovf", ovf0, 1);
    chk("full_both_ack", wr_ack0, 0);
    chk("full_both_dout", dout0, exp_d);
    for (int j = 0; j < 15; j++) pop();
    chk("empty_again", empty0, 1);
    wr_en = 1'b1;
    rd_en = 1'b1;
    din = 14'd77;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
    model.push_back(14'd77);
    chk("empty_both_count", cnt0, 1);
    chk("empty_both_unf", unf0, 1);
    chk("empty_both_ack", wr_ack0, 1);
    chk("empty_both_valid", valid0, 0);
    pop();
    for (int j = 0; j < 12; j++) push(14'(500 + 3 * j));
    for (int j = 0; j < 12; j++) pop();
    for (int j = 0; j < 10; j++) push(14'(9000 + 7 * j));
    chk("wrap_count", cnt0, 10);
    for (int j = 0; j < 10; j++) pop();
    chk("wrap_empty", empty0, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("fw_rst_valid", valid1, 0);
    wr_en = 1'b1;
    din = 14'd1024;
    tick();
    wr_en = 1'b0;
    chk("fw_valid", valid1, 1);
    chk("fw_dout", dout1, 1024);
    tick();
    chk("fw_hold_valid", valid1, 1);
    chk("fw_hold_dout", dout1, 1024);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("fw_ack_valid", valid1, 0);
    chk("fw_ack_empty", empty1, 1);
    for (int j = 0; j < 9; j++) begin
      wr_en = 1'b1;
      din = 14'(1100 + j);
      tick();
    end
    chk("fw_burst_count", cnt1, 9);
    chk("fw_burst_head", dout1, 1100);
    din = 14'd1200;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wr_en = 1'b0;
    chk("fw_mid_rst_count", cnt1, 0);
    chk("fw_mid_rst_empty", empty1, 1);
    chk("fw_mid_rst_valid", valid1, 0);
    chk("std_mid_rst_count", cnt0, 0);
    chk("std_mid_rst_ack", wr_ack0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
